// File: rtl/mem_arbiter_if.sv
// Bus bundle joining two requesting masters, the arbiter and the shared memory.
// The slave modport is the arbiter's view; the master modport is the requesters' and memory's view.
interface mem_arbiter_if;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;

   logic          m0_valid;
   logic          m0_ready;
   logic          m0_instr;
   logic [SW-1:0] m0_wstrb;
   logic [DW-1:0] m0_wdata;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_rdata;

   logic          m1_valid;
   logic          m1_ready;
   logic          m1_instr;
   logic [SW-1:0] m1_wstrb;
   logic [DW-1:0] m1_wdata;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_rdata;

   logic          s_valid;
   logic          s_ready;
   logic          s_instr;
   logic [SW-1:0] s_wstrb;
   logic [DW-1:0] s_wdata;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_rdata;

   logic          timeout_err;

   modport slave (
      input  m0_valid, m0_instr, m0_wstrb, m0_wdata, m0_addr,
      output m0_ready, m0_rdata,
      input  m1_valid, m1_instr, m1_wstrb, m1_wdata, m1_addr,
      output m1_ready, m1_rdata,
      output s_valid, s_instr, s_wstrb, s_wdata, s_addr,
      input  s_ready, s_rdata,
      output timeout_err
   );

   modport master (
      output m0_valid, m0_instr, m0_wstrb, m0_wdata, m0_addr,
      input  m0_ready, m0_rdata,
      output m1_valid, m1_instr, m1_wstrb, m1_wdata, m1_addr,
      input  m1_ready, m1_rdata,
      input  s_valid, s_instr, s_wstrb, s_wdata, s_addr,
      output s_ready, s_rdata,
      input  timeout_err
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter onto a single shared memory port, with an optional
// wait timeout that force-completes a stalled transfer with ERR_DATA.
module mem_arbiter #(
   parameter logic [15:0] TIMEOUT  = 16'd255,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input logic          clk,
   input logic          resetn,
   mem_arbiter_if.slave bus
);
   localparam int unsigned CW = 16;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic          last_grant_q, last_grant_d;
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;

   logic          sel1_c;
   logic          g_valid_c;
   logic          g_instr_c;
   logic [SW-1:0] g_wstrb_c;
   logic [DW-1:0] g_wdata_c;
   logic [AW-1:0] g_addr_c;
   logic          timeout_hit_c;
   logic          ready_c;
   logic [DW-1:0] rdata_c;

   // Request fields of whichever master currently owns the memory
   assign sel1_c        = (state_q == GRANT1);
   assign g_valid_c     = sel1_c ? bus.m1_valid : bus.m0_valid;
   assign g_instr_c     = sel1_c ? bus.m1_instr : bus.m0_instr;
   assign g_wstrb_c     = sel1_c ? bus.m1_wstrb : bus.m0_wstrb;
   assign g_wdata_c     = sel1_c ? bus.m1_wdata : bus.m0_wdata;
   assign g_addr_c      = sel1_c ? bus.m1_addr  : bus.m0_addr;
   assign timeout_hit_c = (TIMEOUT != 16'd0) && (wait_cnt_q == TIMEOUT);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         wait_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         wait_cnt_q   <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      last_grant_d    = last_grant_q;
      wait_cnt_d      = wait_cnt_q;
      bus.s_valid     = 1'b0;
      bus.s_instr     = 1'b0;
      bus.s_wstrb     = '0;
      bus.s_wdata     = '0;
      bus.s_addr      = '0;
      bus.timeout_err = 1'b0;
      ready_c         = 1'b0;
      rdata_c         = '0;

      case (state_q)
         IDLE: begin
            wait_cnt_d = '0;
            if (bus.m0_valid && bus.m1_valid) begin
               state_d = last_grant_q ? GRANT0 : GRANT1;
            end else if (bus.m0_valid) begin
               state_d = GRANT0;
            end else if (bus.m1_valid) begin
               state_d = GRANT1;
            end
         end
         GRANT0, GRANT1: begin
            bus.s_instr = g_instr_c;
            bus.s_wstrb = g_wstrb_c;
            bus.s_wdata = g_wdata_c;
            bus.s_addr  = g_addr_c;
            rdata_c     = bus.s_rdata;
            // s_ready beats the timeout, so s_valid only drops on a timeout without s_ready
            if (!g_valid_c) begin
               state_d = IDLE;
            end else if (bus.s_ready) begin
               bus.s_valid  = 1'b1;
               ready_c      = 1'b1;
               state_d      = IDLE;
               last_grant_d = sel1_c;
            end else if (timeout_hit_c) begin
               ready_c         = 1'b1;
               rdata_c         = ERR_DATA;
               bus.timeout_err = 1'b1;
               state_d         = IDLE;
               last_grant_d    = sel1_c;
            end else begin
               bus.s_valid = 1'b1;
            end
            if (!bus.s_ready && (wait_cnt_q != '1)) begin
               wait_cnt_d = wait_cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.m0_ready = ready_c & ~sel1_c;
   assign bus.m1_ready = ready_c &  sel1_c;
   assign bus.m0_rdata = sel1_c ? '0 : rdata_c;
   assign bus.m1_rdata = sel1_c ? rdata_c : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Cycle-by-cycle vector bench for mem_arbiter: each record holds one cycle of
// stimulus and the outputs expected in that same cycle.
module tb_mem_arbiter;
   localparam logic        H  = 1'b1;
   localparam logic        L  = 1'b0;
   localparam logic [3:0]  S0 = 4'h0;
   localparam logic [31:0] Z  = 32'h0;

   typedef struct packed {
      logic        m0v;
      logic        m0i;
      logic [3:0]  m0s;
      logic [31:0] m0a;
      logic [31:0] m0w;
      logic        m1v;
      logic        m1i;
      logic [3:0]  m1s;
      logic [31:0] m1a;
      logic [31:0] m1w;
      logic        srdy;
      logic [31:0] srd;
      logic        e_m0r;
      logic        e_m1r;
      logic [31:0] e_m0rd;
      logic [31:0] e_m1rd;
      logic        e_sv;
      logic        e_si;
      logic [3:0]  e_sws;
      logic [31:0] e_sa;
      logic [31:0] e_swd;
      logic        e_terr;
   } vec_t;

   logic clk = 1'b0;
   logic resetn;
   int   checks = 0;
   int   errors = 0;
   int   step   = 0;
   vec_t sb_q[$];
   vec_t tbl[12];

   always #5 clk = ~clk;

   mem_arbiter_if bus ();

   mem_arbiter #(
      .TIMEOUT (16'd4),
      .ERR_DATA(32'hDEADBEEF)
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .bus   (bus)
   );

   function automatic vec_t in_v(logic m0v, logic m0i, logic [3:0] m0s, logic [31:0] m0a,
                                 logic [31:0] m0w, logic m1v, logic m1i, logic [3:0] m1s,
                                 logic [31:0] m1a, logic [31:0] m1w, logic srdy, logic [31:0] srd);
      vec_t v;
      v      = '0;
      v.m0v  = m0v;  v.m0i = m0i; v.m0s = m0s; v.m0a = m0a; v.m0w = m0w;
      v.m1v  = m1v;  v.m1i = m1i; v.m1s = m1s; v.m1a = m1a; v.m1w = m1w;
      v.srdy = srdy; v.srd = srd;
      return v;
   endfunction

   function automatic vec_t ex(vec_t vi, logic m0r, logic m1r, logic [31:0] m0rd, logic [31:0] m1rd,
                               logic sv, logic si, logic [3:0] sws, logic [31:0] sa,
                               logic [31:0] swd, logic terr);
      vec_t v;
      v        = vi;
      v.e_m0r  = m0r;  v.e_m1r = m1r; v.e_m0rd = m0rd; v.e_m1rd = m1rd;
      v.e_sv   = sv;   v.e_si  = si;  v.e_sws  = sws;  v.e_sa   = sa;
      v.e_swd  = swd;  v.e_terr = terr;
      return v;
   endfunction

   function automatic vec_t idle_ex(vec_t vi);
      return ex(vi, L, L, Z, Z, L, L, S0, Z, Z, L);
   endfunction

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL step%0d %s: got %h expected %h", step, nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.m0_valid = v.m0v;  bus.m0_instr = v.m0i; bus.m0_wstrb = v.m0s;
      bus.m0_addr  = v.m0a;  bus.m0_wdata = v.m0w;
      bus.m1_valid = v.m1v;  bus.m1_instr = v.m1i; bus.m1_wstrb = v.m1s;
      bus.m1_addr  = v.m1a;  bus.m1_wdata = v.m1w;
      bus.s_ready  = v.srdy; bus.s_rdata  = v.srd;
      sb_q.push_back(v);
   endtask

   task automatic check_out();
      vec_t e;
      step++;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL step%0d scoreboard: got empty queue expected a record", step);
         return;
      end
      e = sb_q.pop_front();
      cmp("m0_ready",    32'(bus.m0_ready),    32'(e.e_m0r));
      cmp("m1_ready",    32'(bus.m1_ready),    32'(e.e_m1r));
      cmp("m0_rdata",    bus.m0_rdata,         e.e_m0rd);
      cmp("m1_rdata",    bus.m1_rdata,         e.e_m1rd);
      cmp("s_valid",     32'(bus.s_valid),     32'(e.e_sv));
      cmp("s_instr",     32'(bus.s_instr),     32'(e.e_si));
      cmp("s_wstrb",     32'(bus.s_wstrb),     32'(e.e_sws));
      cmp("s_addr",      bus.s_addr,           e.e_sa);
      cmp("s_wdata",     bus.s_wdata,          e.e_swd);
      cmp("timeout_err", 32'(bus.timeout_err), 32'(e.e_terr));
   endtask

   task automatic cycle(input vec_t v);
      @(posedge clk);
      #1;
      drive(v);
      @(negedge clk);
      check_out();
   endtask

   task automatic release_cycle(input vec_t v);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      drive(v);
      @(negedge clk);
      check_out();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected end of test");
      $fatal(1);
   end

   initial begin
      vec_t rd0, wr1, both, both2, tmo, tie, drop, zero;
      zero = in_v(L, L, S0, Z, Z, L, L, S0, Z, Z, L, Z);
      rd0  = in_v(H, L, S0, 32'h10, Z, L, L, S0, Z, Z, H, 32'h11223344);
      wr1  = in_v(L, L, S0, Z, Z, H, L, 4'b0011, 32'h104, 32'hCAFEF00D, L, 32'h12345678);
      both = in_v(H, H, S0, 32'h20, Z, H, L, S0, 32'h30, Z, H, 32'hA5A5A5A5);

      tbl[0]  = idle_ex(rd0);
      tbl[1]  = ex(rd0, H, L, 32'h11223344, Z, H, L, S0, 32'h10, Z, L);
      tbl[2]  = idle_ex(wr1);
      tbl[3]  = ex(wr1, L, L, Z, 32'h12345678, H, L, 4'b0011, 32'h104, 32'hCAFEF00D, L);
      wr1.srdy = H;
      tbl[4]  = ex(wr1, L, H, Z, 32'h12345678, H, L, 4'b0011, 32'h104, 32'hCAFEF00D, L);
      tbl[5]  = idle_ex(both);
      tbl[6]  = ex(both, H, L, 32'hA5A5A5A5, Z, H, H, S0, 32'h20, Z, L);
      tbl[7]  = idle_ex(both);
      tbl[8]  = ex(both, L, H, Z, 32'hA5A5A5A5, H, L, S0, 32'h30, Z, L);
      tbl[9]  = idle_ex(both);
      tbl[10] = ex(both, H, L, 32'hA5A5A5A5, Z, H, H, S0, 32'h20, Z, L);
      tbl[11] = idle_ex(zero);

      // Reset: all outputs low even with both masters requesting
      resetn = 1'b0;
      cycle(idle_ex(both));
      cycle(idle_ex(both));
      release_cycle(idle_ex(zero));

      // Single read, write forward, alternating contention
      for (int i = 0; i < 12; i++) cycle(tbl[i]);

      // Timeout: s_ready held low, forced completion on the 5th GRANT0 cycle
      tmo = in_v(H, L, S0, 32'h40, Z, L, L, S0, Z, Z, L, 32'h77777777);
      cycle(idle_ex(tmo));
      for (int k = 0; k < 4; k++) cycle(ex(tmo, L, L, 32'h77777777, Z, H, L, S0, 32'h40, Z, L));
      cycle(ex(tmo, H, L, 32'hDEADBEEF, Z, L, L, S0, 32'h40, Z, H));
      cycle(idle_ex(zero));

      // Tie: s_ready arrives exactly in the timeout cycle
      tie = in_v(L, L, S0, Z, Z, H, L, S0, 32'h50, Z, L, 32'h88888888);
      cycle(idle_ex(tie));
      for (int k = 0; k < 4; k++) cycle(ex(tie, L, L, Z, 32'h88888888, H, L, S0, 32'h50, Z, L));
      tie.srdy = H;
      cycle(ex(tie, L, H, Z, 32'h88888888, H, L, S0, 32'h50, Z, L));
      cycle(idle_ex(zero));

      // Valid dropped mid-grant: no ready, last_grant stays 1 so m0 wins next contention
      drop = in_v(H, L, S0, 32'h60, Z, L, L, S0, Z, Z, L, 32'h99999999);
      cycle(idle_ex(drop));
      cycle(ex(drop, L, L, 32'h99999999, Z, H, L, S0, 32'h60, Z, L));
      drop.m0v = L;
      cycle(ex(drop, L, L, 32'h99999999, Z, L, L, S0, 32'h60, Z, L));
      both2 = in_v(H, L, S0, 32'h70, Z, H, L, S0, 32'h80, Z, H, 32'h0BADF00D);
      cycle(idle_ex(both2));
      cycle(ex(both2, H, L, 32'h0BADF00D, Z, H, L, S0, 32'h70, Z, L));
      cycle(idle_ex(both2));
      cycle(ex(both2, L, H, Z, 32'h0BADF00D, H, L, S0, 32'h80, Z, L));

      // Reset mid-GRANT1: outputs collapse without waiting for a clock edge
      #1;
      resetn = 1'b0;
      #1;
      step++;
      cmp("async s_valid",  32'(bus.s_valid),  Z);
      cmp("async m1_ready", 32'(bus.m1_ready), Z);
      cmp("async m1_rdata", bus.m1_rdata,      Z);
      cmp("async s_addr",   bus.s_addr,        Z);
      cycle(idle_ex(both2));
      cycle(idle_ex(both2));
      release_cycle(idle_ex(both2));
      cycle(ex(both2, H, L, 32'h0BADF00D, Z, H, L, S0, 32'h70, Z, L));
      cycle(idle_ex(zero));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
